seq_pattern_tx: RTL
===================

# seq_pattern_tx

Serial bit-pattern transmitter for the sequence-detection path. It accepts a pattern of up to `MAX_LEN` bits, plus a pass count and an inter-pass gap, over a valid/ready request. It then drives the pattern MSB-first, one bit per clock, on a registered serial line. The serial line feeds the Moore sequence detectors (e.g. 10101-style overlapping detectors) as stimulus source and link-side driver. Bursts with and without gaps exercise both overlapping and non-overlapping detection.

## Interface
- `MAX_LEN`, 8: maximum pattern length in bits.
- `LEN_W`, 4: width of `len`; must hold `MAX_LEN`.
- `CNT_W`, 4: width of `reps` and `gap`.
- `IDLE_LVL`, 0: value driven on `ser_out` when no bit is being sent.
- `clk  in  1`: clock; all state updates on the rising edge.
- `rst  in  1`: reset, asynchronous, active-high.
- `req_valid  in  1`: request present.
- `req_ready  out  1`: block can accept a request; combinational, equals (state==IDLE) && !abort.
- `pat  in  MAX_LEN`: pattern; the active bits are `pat[len-1:0]`, and `pat[len-1]` is sent first.
- `len  in  LEN_W`: number of bits per pass; legal range is 1..MAX_LEN.
- `reps  in  CNT_W`: number of passes; legal range is 1..2^CNT_W-1.
- `gap  in  CNT_W`: number of idle cycles between passes; 0 means passes are back-to-back.
- `abort  in  1`: synchronous cancel.
- `ser_out  out  1`: serial data, registered.
- `ser_valid  out  1`: high on every cycle that `ser_out` carries a pattern bit.
- `busy  out  1`: high in the SEND and GAP states.
- `done  out  1`: one-cycle pulse after the last bit of the final pass.
- `err  out  1`: one-cycle pulse when an illegal request is consumed.

## Operation
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - On `req_valid && req_ready` with a legal request, capture `pat`, `len`, `reps`, `gap` and go to SEND.
  - On an illegal request (`len==0`, `len>MAX_LEN`, or `reps==0`), consume the request, pulse `err` in the next cycle, and stay in IDLE.
- SEND:
  - Drive the current bit and decrement the bit counter.
  - After the last bit of a pass:
    - final pass → IDLE with `done` pulse;
    - else if `gap>0` → GAP;
    - else stay in SEND, reload the shift register and bit counter, and decrement the pass counter.
- GAP:
  - `ser_out`=IDLE_LVL and `ser_valid`=0 for exactly `gap` cycles.
  - Then go to SEND with the shift register reloaded.
- `abort`:
  - In SEND or GAP: go to IDLE next cycle; no `done`; `ser_valid`=0 from the next cycle on.
  - In IDLE: `req_ready` is low, so no request is accepted; abort wins over a simultaneous `req_valid`.
- Captured request fields are frozen while busy; input changes are ignored until the next acceptance.
- `rst` mid-operation: immediately return to IDLE; all outputs take their reset values and the partial pattern is discarded.

## Timing
- Reset values: `ser_out`=IDLE_LVL, `ser_valid`=0, `busy`=0, `done`=0, `err`=0; `req_ready`=1 once `rst` deasserts.
- Request accepted in cycle T:
  - bit k (k=0..len-1) of pass p (p=0..reps-1) appears on `ser_out`/`ser_valid` in cycle T+1+p·(len+gap)+k.
  - `done` pulses in cycle T+reps·len+(reps−1)·gap+1.
  - `req_ready` is high in that same `done` cycle, so a new request can be accepted with no dead cycle.
- `busy` is high from T+1 through the last bit cycle.
- Illegal request in cycle T: `err` pulses at T+1; `busy` stays 0.
- `abort` asserted in cycle A: `ser_valid`=0 and `busy`=0 from A+1; `req_ready` returns at A+1 if `abort` is low.

## Structure
- Package `seq_pkg` holds:
  - the state enum (IDLE/SEND/GAP);
  - default `MAX_LEN`, `LEN_W`, `CNT_W` constants;
  - an `IDLE_LVL` constant shared with the detectors.
- Sub-module `pattern_shreg`: a loadable MAX_LEN-bit left-aligning shift register, with load, shift, and an MSB output.
- The FSM, the bit, pass and gap counters, and the output registers live in the top module.

## Test plan
- `pat`=5'b10101, `len`=5, `reps`=1, `gap`=0 at T → `ser_out`=1,0,1,0,1 at T+1..T+5 with `ser_valid`=1; `done` at T+6.
- Same pattern, `reps`=2, `gap`=0 → 1010110101 contiguous over T+1..T+10; `done` at T+11; a downstream overlapping 10101 detector fires twice.
- `reps`=2, `gap`=2 → 10101, then two idle cycles (`ser_valid`=0, `ser_out`=IDLE_LVL), then 10101 at T+8..T+12; `done` at T+13.
- `len`=0 or `len`=9 (with `MAX_LEN`=8), or `reps`=0 → request consumed, `err` at T+1, no `ser_valid`, `busy`=0.
- `abort` at bit 3 of the first pass → `ser_valid`=0 next cycle, no `done`; a new request accepted in that same cycle starts cleanly.
- `rst` pulsed mid-GAP → all outputs at their reset values immediately; after release, a back-to-back request is accepted in the `done` cycle of the previous one.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and defaults for the sequence-detection stimulus path.
package seq_pkg;

  localparam int unsigned DEF_MAX_LEN = 8;
  localparam int unsigned DEF_LEN_W   = 4;
  localparam int unsigned DEF_CNT_W   = 4;

  // Line level while no pattern bit is present; detectors assume the same value.
  localparam logic SEQ_IDLE_LVL = 1'b0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StGap  = 2'd2
  } seq_state_e;

  function automatic logic req_is_legal(input int unsigned len, input int unsigned reps,
                                        input int unsigned max_len);
    return (len != 0) && (len <= max_len) && (reps != 0);
  endfunction

endpackage

// File: rtl/pattern_shreg.sv
// Loadable shift register that left-aligns a len-bit pattern so bits leave MSB-first.
module pattern_shreg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_pat,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_first,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_aligned;
  logic [LEN_W-1:0] w_shamt;

  assign w_shamt   = LEN_W'(WIDTH) - i_len;
  assign w_aligned = i_pat << w_shamt;
  // The first bit goes straight to the output register, so only the rest is stored.
  assign o_first   = w_aligned[WIDTH-1];
  assign o_msb     = r_data[WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= {w_aligned[WIDTH-2:0], 1'b0};
    end else if (i_shift) begin
      r_data <= {r_data[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: sends a captured pattern MSB-first for a number of
// passes, optionally separated by idle gaps, on a registered serial line.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int unsigned MAX_LEN  = DEF_MAX_LEN,
  parameter int unsigned LEN_W    = DEF_LEN_W,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter logic        IDLE_LVL = SEQ_IDLE_LVL
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [MAX_LEN-1:0] i_pat,
  input  logic [LEN_W-1:0]   i_len,
  input  logic [CNT_W-1:0]   i_reps,
  input  logic [CNT_W-1:0]   i_gap,
  input  logic               i_abort,
  output logic               o_ser_out,
  output logic               o_ser_valid,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  seq_state_e r_state, w_state_nxt;

  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_gap;

  logic [LEN_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [CNT_W-1:0] r_pass_cnt, w_pass_cnt_nxt;
  logic [CNT_W-1:0] r_gap_cnt, w_gap_cnt_nxt;

  logic r_ser_out, w_ser_out_nxt;
  logic r_ser_valid, w_ser_valid_nxt;
  logic r_done, w_done_nxt;
  logic r_err, w_err_nxt;

  logic w_accept, w_legal, w_capture, w_reload;
  logic w_load, w_shift, w_first, w_msb;
  logic [MAX_LEN-1:0] w_ld_pat;
  logic [LEN_W-1:0]   w_ld_len;

  assign o_req_ready = (r_state == StIdle) && !i_abort;
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_legal     = req_is_legal(32'(i_len), 32'(i_reps), MAX_LEN);

  // Fresh request fields on acceptance, frozen copies on every later reload.
  assign w_ld_pat = (r_state == StIdle) ? i_pat : r_pat;
  assign w_ld_len = (r_state == StIdle) ? i_len : r_len;

  pattern_shreg #(
    .WIDTH (MAX_LEN),
    .LEN_W (LEN_W)
  ) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_pat   (w_ld_pat),
    .i_len   (w_ld_len),
    .o_first (w_first),
    .o_msb   (w_msb)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_pass_cnt_nxt  = r_pass_cnt;
    w_gap_cnt_nxt   = r_gap_cnt;
    w_ser_out_nxt   = IDLE_LVL;
    w_ser_valid_nxt = 1'b0;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    w_capture       = 1'b0;
    w_reload        = 1'b0;
    w_load          = 1'b0;
    w_shift         = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (w_legal) begin
            w_capture       = 1'b1;
            w_load          = 1'b1;
            w_state_nxt     = StSend;
            w_ser_out_nxt   = w_first;
            w_ser_valid_nxt = 1'b1;
            w_bit_cnt_nxt   = i_len - LEN_W'(1);
            w_pass_cnt_nxt  = i_reps - CNT_W'(1);
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      StSend: begin
        // Counters hold bits/passes remaining after the one currently on the line.
        if (i_abort) begin
          w_state_nxt = StIdle;
        end else if (r_bit_cnt != '0) begin
          w_shift         = 1'b1;
          w_ser_out_nxt   = w_msb;
          w_ser_valid_nxt = 1'b1;
          w_bit_cnt_nxt   = r_bit_cnt - LEN_W'(1);
        end else if (r_pass_cnt == '0) begin
          w_state_nxt = StIdle;
          w_done_nxt  = 1'b1;
        end else if (r_gap != '0) begin
          w_state_nxt   = StGap;
          w_gap_cnt_nxt = r_gap - CNT_W'(1);
        end else begin
          w_reload = 1'b1;
        end
      end
      StGap: begin
        if (i_abort) begin
          w_state_nxt = StIdle;
        end else if (r_gap_cnt == '0) begin
          w_reload = 1'b1;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase

    if (w_reload) begin
      w_load          = 1'b1;
      w_state_nxt     = StSend;
      w_ser_out_nxt   = w_first;
      w_ser_valid_nxt = 1'b1;
      w_bit_cnt_nxt   = r_len - LEN_W'(1);
      w_pass_cnt_nxt  = r_pass_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_pat       <= '0;
      r_len       <= '0;
      r_gap       <= '0;
      r_bit_cnt   <= '0;
      r_pass_cnt  <= '0;
      r_gap_cnt   <= '0;
      r_ser_out   <= IDLE_LVL;
      r_ser_valid <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_pass_cnt  <= w_pass_cnt_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_ser_out   <= w_ser_out_nxt;
      r_ser_valid <= w_ser_valid_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      if (w_capture) begin
        r_pat <= i_pat;
        r_len <= i_len;
        r_gap <= i_gap;
      end
    end
  end

  assign o_ser_out   = r_ser_out;
  assign o_ser_valid = r_ser_valid;
  assign o_busy      = (r_state != StIdle);
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule
